mux_scan: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer and the successor of the 4:1 single-bit combinational mux. It has two modes. In manual mode an external select picks the channel. In scan mode an internal dwell counter steps through every channel in turn. The block sits between grouped data sources and a single observation or display path. It adds a registered output, channel tag, valid strobe and wrap pulse.

---
 rtl/mux_scan.sv | 137 +++++++++++++
 tb/tb_mux_scan.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit multiplexer with manual select and
// an automatic dwell-based scan mode. It produces a registered data output,
// the tag of the channel that produced it, a valid strobe and a wrap pulse
// that marks each completed pass through all channels.
module mux_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 4,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    output logic [WIDTH-1:0]            out,
    output logic [SEL_W-1:0]            out_ch,
    output logic                        out_valid,
    output logic                        wrap
);

    localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    typedef enum logic {
        S_MAN  = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_out;
    logic [SEL_W-1:0]  r_outCh;
    logic              r_outValid;
    logic              r_wrap;
    logic [SEL_W-1:0]  r_scanIdx;
    logic [DW_W-1:0]   r_dwellCnt;

    state_t            w_nextState;
    logic [WIDTH-1:0]  w_nextOut;
    logic [SEL_W-1:0]  w_nextCh;
    logic              w_nextValid;
    logic              w_nextWrap;
    logic [SEL_W-1:0]  w_nextIdx;
    logic [DW_W-1:0]   w_nextDwell;
    logic [WIDTH-1:0]  w_manData;
    logic [WIDTH-1:0]  w_scanData;
    logic              w_selOk;

    // Channel pickers for the manual select and the scan index; an out-of-range select picks nothing
    always_comb begin
        w_manData  = '0;
        w_scanData = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel == SEL_W'(k)) begin
                w_manData = in_data[k*WIDTH +: WIDTH];
            end
            if (r_scanIdx == SEL_W'(k)) begin
                w_scanData = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_selOk = (32'(sel) < CHANNELS);

    // Mode register: follows the mode input on enabled edges so wrap can tell a real wrap from scan entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_MAN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and next-output logic; everything holds and strobes drop unless enabled
    always_comb begin
        w_nextState = r_state;
        w_nextOut   = r_out;
        w_nextCh    = r_outCh;
        w_nextValid = 1'b0;
        w_nextWrap  = 1'b0;
        w_nextIdx   = r_scanIdx;
        w_nextDwell = r_dwellCnt;
        if (en) begin
            if (mode) begin
                w_nextState = S_SCAN;
                w_nextOut   = w_scanData;
                w_nextCh    = r_scanIdx;
                w_nextValid = 1'b1;
                w_nextWrap  = (r_state == S_SCAN) && (r_scanIdx == '0) && (r_dwellCnt == '0);
                if (32'(r_dwellCnt) < DWELL - 1) begin
                    w_nextDwell = r_dwellCnt + DW_W'(1);
                end else begin
                    w_nextDwell = '0;
                    if (32'(r_scanIdx) == CHANNELS - 1) begin
                        w_nextIdx = '0;
                    end else begin
                        w_nextIdx = r_scanIdx + SEL_W'(1);
                    end
                end
            end else begin
                w_nextState = S_MAN;
                w_nextIdx   = '0;
                w_nextDwell = '0;
                if (w_selOk) begin
                    w_nextOut   = w_manData;
                    w_nextCh    = sel;
                    w_nextValid = 1'b1;
                end
            end
        end
    end

    // Output and scan-position registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_outCh    <= '0;
            r_outValid <= 1'b0;
            r_wrap     <= 1'b0;
            r_scanIdx  <= '0;
            r_dwellCnt <= '0;
        end else begin
            r_out      <= w_nextOut;
            r_outCh    <= w_nextCh;
            r_outValid <= w_nextValid;
            r_wrap     <= w_nextWrap;
            r_scanIdx  <= w_nextIdx;
            r_dwellCnt <= w_nextDwell;
        end
    end

    assign out       = r_out;
    assign out_ch    = r_outCh;
    assign out_valid = r_outValid;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: drives two mux_scan instances (8-bit x 4 channels x dwell 4,
// and 1-bit x 3 channels x dwell 1) and checks them every cycle against a
// position-counting reference, plus literal expectations for known sequences.
module tb_mux_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [1:0]  selA;
    logic [1:0]  selB;
    logic [31:0] dataA;
    logic [2:0]  dataB;

    logic [7:0]  outA;
    logic [1:0]  chA;
    logic        vA;
    logic        wA;
    logic [0:0]  outB;
    logic [1:0]  chB;
    logic        vB;
    logic        wB;

    int checks   = 0;
    int failures = 0;

    // Reference state per instance: scan position counts enabled scan edges since entry
    int pos[2];
    int eOut[2];
    int eCh[2];
    int eV[2];
    int eW[2];
    bit cmpOn = 1'b0;

    int seq[20] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0,0,0};
    int byteOf[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    always #5 clk = ~clk;

    mux_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) dutA (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(selA), .in_data(dataA),
        .out(outA), .out_ch(chA), .out_valid(vA), .wrap(wA)
    );

    mux_scan #(.WIDTH(1), .CHANNELS(3), .DWELL(1)) dutB (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(selB), .in_data({dataB}),
        .out(outB), .out_ch(chB), .out_valid(vB), .wrap(wB)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic [1:0] sa, input logic [1:0] sb);
        rst  = r;
        en   = e;
        mode = m;
        selA = sa;
        selB = sb;
        @(posedge clk);
        #1;
    endtask

    // Reference model: channel during scan is (pos / DWELL) mod CHANNELS, wrap on every full period
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int c;
            int d;
            int w;
            int s;
            int ch;
            logic [31:0] data;
            c    = (i == 0) ? 4 : 3;
            d    = (i == 0) ? 4 : 1;
            w    = (i == 0) ? 8 : 1;
            s    = (i == 0) ? int'(selA) : int'(selB);
            data = (i == 0) ? dataA : {29'd0, dataB};
            if (rst) begin
                eOut[i] = 0; eCh[i] = 0; eV[i] = 0; eW[i] = 0; pos[i] = 0;
            end else if (!en) begin
                eV[i] = 0; eW[i] = 0;
            end else if (mode) begin
                ch      = (pos[i] / d) % c;
                eCh[i]  = ch;
                eOut[i] = int'((data >> (ch * w)) & ((32'd1 << w) - 32'd1));
                eV[i]   = 1;
                eW[i]   = (pos[i] > 0 && (pos[i] % (c * d)) == 0) ? 1 : 0;
                pos[i]  = pos[i] + 1;
            end else begin
                pos[i] = 0;
                eW[i]  = 0;
                if (s < c) begin
                    eCh[i]  = s;
                    eOut[i] = int'((data >> (s * w)) & ((32'd1 << w) - 32'd1));
                    eV[i]   = 1;
                end else begin
                    eV[i] = 0;
                end
            end
        end
    end

    // Compare process: every output of both instances against the reference, mid-cycle
    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("A.out",   int'(outA), eOut[0]);
            checkOutput("A.ch",    int'(chA),  eCh[0]);
            checkOutput("A.valid", int'(vA),   eV[0]);
            checkOutput("A.wrap",  int'(wA),   eW[0]);
            checkOutput("B.out",   int'(outB), eOut[1]);
            checkOutput("B.ch",    int'(chB),  eCh[1]);
            checkOutput("B.valid", int'(vB),   eV[1]);
            checkOutput("B.wrap",  int'(wB),   eW[1]);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b1; selA = 2'd0; selB = 2'd0;
        dataA = 32'd0; dataB = 3'd0;
        cmpOn = 1'b1;

        // Reset with everything else toggling
        for (int k = 0; k < 3; k++) begin
            dataA = $urandom;
            dataB = 3'($urandom);
            applyStimulus(1'b1, 1'b1, 1'b1, 2'($urandom), 2'($urandom));
            checkOutput("rst.outA", int'(outA), 0);
            checkOutput("rst.chA",  int'(chA), 0);
            checkOutput("rst.vA",   int'(vA), 0);
            checkOutput("rst.wA",   int'(wA), 0);
        end

        // Manual sweep on the 8-bit instance
        dataA = 32'hD4C3B2A1;
        dataB = 3'b101;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'(k), 2'd0);
            checkOutput("man.outA", int'(outA), byteOf[k]);
            checkOutput("man.chA",  int'(chA), k);
            checkOutput("man.vA",   int'(vA), 1);
        end

        // Scan entry and one full period plus the start of the next
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd2, 2'd0);
            checkOutput("scan.chA",   int'(chA), seq[k]);
            checkOutput("scan.outA",  int'(outA), byteOf[seq[k]]);
            checkOutput("scan.wrapA", int'(wA), (k == 16) ? 1 : 0);
            checkOutput("scan.vA",    int'(vA), 1);
        end

        // Two edges into channel 1, then stall for three cycles
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
            checkOutput("pre.chA", int'(chA), 1);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 2'd3, 2'd3);
            checkOutput("stall.chA",  int'(chA), 1);
            checkOutput("stall.outA", int'(outA), 8'hB2);
            checkOutput("stall.vA",   int'(vA), 0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
            checkOutput("resume.chA", int'(chA), (k < 2) ? 1 : 2);
            checkOutput("resume.vA",  int'(vA), 1);
        end

        // Leave scan on channel 2, then re-enter
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 2'd0);
        checkOutput("switch.chA",  int'(chA), 3);
        checkOutput("switch.outA", int'(outA), 8'hD4);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
            checkOutput("reenter.chA", int'(chA), (k < 4) ? 0 : 1);
            checkOutput("reenter.wA",  int'(wA), 0);
        end

        // Three-channel instance: out-of-range manual select, then fast scan
        dataB = 3'b100;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 2'd2);
        checkOutput("b3.outB", int'(outB), 1);
        checkOutput("b3.chB",  int'(chB), 2);
        checkOutput("b3.vB",   int'(vB), 1);
        dataB = 3'b011;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 2'd3);
        checkOutput("b3hold.outB", int'(outB), 1);
        checkOutput("b3hold.chB",  int'(chB), 2);
        checkOutput("b3hold.vB",   int'(vB), 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 2'd3);
            checkOutput("b3scan.chB", int'(chB), (k < 3) ? k : 0);
            checkOutput("b3scan.wB",  int'(wB), (k == 3) ? 1 : 0);
        end

        // Randomised traffic; the compare process checks every cycle
        for (int k = 0; k < 400; k++) begin
            logic r;
            logic e;
            logic m;
            r = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 7) == 0) ? ~mode : mode;
            dataA = $urandom;
            dataB = 3'($urandom);
            applyStimulus(r, e, m, 2'($urandom), 2'($urandom));
        end

        @(negedge clk);
        cmpOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
